// File: rtl/mlp_pkg.sv
// Shared widths and fixed network constants for the two-layer MLP scorer.
package mlp_pkg;

    localparam int MLP_N1  = 98;
    localparam int MLP_N2  = 10;
    localparam int MLP_W_X = 4;
    localparam int MLP_W_K = 4;
    localparam int MLP_W_Y = 16;
    localparam int N_PIX   = MLP_N1 / 2;
    localparam int W_B     = 8;

    localparam int W_SUM_FC1     = MLP_W_X + MLP_W_K + $clog2(N_PIX);
    localparam int W_SUM_FC1_POL = 1 + MLP_W_K + $clog2(N_PIX);
    localparam int W_SUM_FC2     = MLP_W_X + MLP_W_K + $clog2(MLP_N2);
    localparam int W_PRE         = W_SUM_FC1 + 1;
    localparam int SHIFT1        = 6;
    localparam int H_MAX         = (1 << MLP_W_X) - 1;

    typedef logic signed [MLP_W_K-1:0] weight_t;
    typedef logic signed [W_B-1:0]     bias_t;

    // Even hidden neurons reward magnitude, odd ones penalise it.
    localparam weight_t K1_MAG [MLP_N2][N_PIX] = '{
        '{default: 4'sd1}, '{default: -4'sd1},
        '{default: 4'sd1}, '{default: -4'sd1},
        '{default: 4'sd1}, '{default: -4'sd1},
        '{default: 4'sd1}, '{default: -4'sd1},
        '{default: 4'sd1}, '{default: -4'sd1}
    };
    localparam weight_t K1_POL [MLP_N2][N_PIX] = '{default: 4'sd1};
    localparam bias_t   B1 [MLP_N2] = '{default: 8'sd0};
    localparam weight_t K2 [MLP_N2] = '{default: 4'sd1};
    localparam bias_t   B2 = 8'sd0;

endpackage

// File: rtl/mlp_neuron.sv
// One FC1 hidden neuron: weighted sums, bias, ReLU, shift and saturation, all combinational.
module mlp_neuron
    import mlp_pkg::*;
#(
    parameter int J    = 0,
    parameter int N_IN = N_PIX,
    parameter int W_X  = MLP_W_X
) (
    input  logic [N_IN-1:0][W_X-1:0] i_mag,
    input  logic [N_IN-1:0]          i_pol,
    output logic [W_X-1:0]           o_h
);

    logic signed [W_SUM_FC1-1:0]     w_s_mag;
    logic signed [W_SUM_FC1_POL-1:0] w_s_pol;
    logic signed [W_PRE-1:0]         w_p;
    logic signed [W_PRE-1:0]         w_shift;

    always_comb begin
        w_s_mag = '0;
        w_s_pol = '0;
        for (int i = 0; i < N_IN; i++) begin
            // Magnitudes are unsigned: zero-extend before the signed multiply.
            w_s_mag = w_s_mag + W_SUM_FC1'($signed({1'b0, i_mag[i]})) * W_SUM_FC1'(K1_MAG[J][i]);
            if (i_pol[i])
                w_s_pol = w_s_pol + W_SUM_FC1_POL'(K1_POL[J][i]);
        end
    end

    assign w_p     = W_PRE'(w_s_mag) + W_PRE'(w_s_pol) + W_PRE'(B1[J]);
    assign w_shift = w_p >>> SHIFT1;

    always_comb begin
        o_h = '0;
        if (!w_p[W_PRE-1]) begin
            if (w_shift > W_PRE'(H_MAX))
                o_h = W_X'(H_MAX);
            else
                o_h = w_shift[W_X-1:0];
        end
    end

endmodule

// File: rtl/mlp.sv
// Three-stage MLP scorer: input register, hidden-activation register, output register.
module mlp
    import mlp_pkg::*;
#(
    parameter int N1  = MLP_N1,
    parameter int N2  = MLP_N2,
    parameter int W_X = MLP_W_X,
    parameter int W_K = MLP_W_K,
    parameter int W_Y = MLP_W_Y
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N1/2-1:0][W_X-1:0]    in_mag,
    input  logic [N1/2-1:0]             in_pol,
    output logic [W_Y-1:0]              out
);

    localparam int W_FC2 = W_X + W_K + $clog2(N2);

    logic [N1/2-1:0][W_X-1:0] r_mag;
    logic [N1/2-1:0]          r_pol;
    logic [N2-1:0][W_X-1:0]   w_h;
    logic [N2-1:0][W_X-1:0]   r_h;
    logic signed [W_FC2-1:0]  w_y;
    logic [W_Y-1:0]           r_out;

    for (genvar j = 0; j < N2; j++) begin : g_fc1
        mlp_neuron #(
            .J    (j),
            .N_IN (N1/2),
            .W_X  (W_X)
        ) u_neuron (
            .i_mag (r_mag),
            .i_pol (r_pol),
            .o_h   (w_h[j])
        );
    end

    // FC2 has no output activation; the score stays signed.
    always_comb begin
        w_y = W_FC2'(B2);
        for (int j = 0; j < N2; j++)
            w_y = w_y + W_FC2'($signed({1'b0, r_h[j]})) * W_FC2'(K2[j]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mag <= '0;
            r_pol <= '0;
            r_h   <= '0;
            r_out <= '0;
        end else begin
            r_mag <= in_mag;
            r_pol <= in_pol;
            r_h   <= w_h;
            r_out <= W_Y'(w_y);
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_mlp.sv
// Scoreboard bench for mlp: driver pushes expected scores, a monitor pops them at the pipeline exit.
module tb_mlp;
    import mlp_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [48:0][3:0]     in_mag = '0;
    logic [48:0]          in_pol = '0;
    logic [15:0]          out;

    logic [15:0]          exp_q[$];
    logic [2:0]           v = '0;
    logic                 mon_en = 1'b0;
    int                   checks = 0;
    int                   errors = 0;

    mlp dut (
        .clk    (clk),
        .rst    (rst),
        .in_mag (in_mag),
        .in_pol (in_pol),
        .out    (out)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Independent integer reference of the network.
    function automatic logic [15:0] model(input logic [48:0][3:0] m, input logic [48:0] p);
        int y;
        int s;
        int h;
        y = int'(B2);
        for (int j = 0; j < MLP_N2; j++) begin
            s = int'(B1[j]);
            for (int i = 0; i < 49; i++) begin
                s += int'(m[i]) * int'(K1_MAG[j][i]);
                if (p[i]) s += int'(K1_POL[j][i]);
            end
            h = (s < 0) ? 0 : s / 64;
            if (h > 15) h = 15;
            y += h * int'(K2[j]);
        end
        return 16'(y);
    endfunction

    // driver tasks
    task automatic drive_vec(input logic [48:0][3:0] m, input logic [48:0] p,
                             input logic [15:0] e, input logic r);
        @(posedge clk);
        #1;
        rst    = r;
        in_mag = m;
        in_pol = p;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [3:0] mag, input logic pol, input logic [15:0] e, input logic r);
        logic [48:0][3:0] m;
        logic [48:0]      p;
        for (int i = 0; i < 49; i++) begin
            m[i] = mag;
            p[i] = pol;
        end
        drive_vec(m, p, e, r);
    endtask

    // scoreboard: a reset edge discards every in-flight expectation
    always @(posedge clk) begin
        if (rst) begin
            v <= '0;
            exp_q.delete();
        end else begin
            v <= {v[1:0], 1'b1};
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (mon_en) begin
            checks++;
            if (v[2]) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_underflow t=%0t got=%0d required=queued value", $time, $signed(out));
                end else begin
                    e = exp_q.pop_front();
                    if (out !== e) begin
                        errors++;
                        $display("FAIL out t=%0t got=%0d required=%0d", $time, $signed(out), $signed(e));
                    end
                end
            end else if (out !== 16'd0) begin
                errors++;
                $display("FAIL out_reset t=%0t got=%0d required=0", $time, $signed(out));
            end
        end
    end

    initial begin
        logic [48:0][3:0] m;
        logic [48:0]      p;

        drive(4'd0, 1'b0, 16'd0, 1'b1);
        mon_en = 1'b1;
        drive(4'd0, 1'b0, 16'd0, 1'b1);
        drive(4'd0, 1'b0, 16'd0, 1'b0);

        // single patterns, then three back-to-back distinct vectors
        drive(4'd15, 1'b1, 16'd60, 1'b0);
        drive(4'd0,  1'b0, 16'd0,  1'b0);
        drive(4'd15, 1'b1, 16'd60, 1'b0);
        drive(4'd2,  1'b0, 16'd5,  1'b0);
        drive(4'd0,  1'b1, 16'd0,  1'b0);
        drive(4'd15, 1'b0, 16'd55, 1'b0);
        drive(4'd8,  1'b1, 16'd30, 1'b0);
        drive(4'd1,  1'b1, 16'd5,  1'b0);
        drive(4'd7,  1'b0, 16'd25, 1'b0);
        drive(4'd4,  1'b1, 16'd15, 1'b0);

        // one-cycle reset in the middle of a stream
        repeat (4) drive(4'd15, 1'b1, 16'd60, 1'b0);
        drive(4'd15, 1'b1, 16'd60, 1'b1);
        repeat (6) drive(4'd15, 1'b1, 16'd60, 1'b0);

        for (int n = 0; n < 100; n++) begin
            for (int i = 0; i < 49; i++) begin
                m[i] = 4'($urandom_range(0, 15));
                p[i] = 1'($urandom_range(0, 1));
            end
            drive_vec(m, p, model(m, p), 1'b0);
        end

        repeat (4) drive(4'd0, 1'b0, 16'd0, 1'b0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
